// File: rtl/ifu_ift2mem.sv
// rtl/ifu_ift2mem.sv - instruction-fetch to memory-port adapter
// Credit-limited command issue, in-order response FIFO, flush kill counting.
module ifu_ift2mem #(
    parameter int PC_SIZE    = 32,
    parameter int INSTR_SIZE = 32,
    parameter int OUTS_DEPTH = 2,
    parameter logic [INSTR_SIZE-1:0] INSTR_NOP = INSTR_SIZE'(32'h0000_0013)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ifu_req_valid,
    output logic                  ifu_req_ready,
    input  logic [PC_SIZE-1:0]    ifu_req_pc,
    output logic                  ifu_rsp_valid,
    input  logic                  ifu_rsp_ready,
    output logic [INSTR_SIZE-1:0] ifu_rsp_instr,
    output logic                  ifu_rsp_err,
    input  logic                  flush_req,
    output logic                  mem_cmd_valid,
    input  logic                  mem_cmd_ready,
    output logic [PC_SIZE-1:0]    mem_cmd_addr,
    input  logic                  mem_rsp_valid,
    output logic                  mem_rsp_ready,
    input  logic [INSTR_SIZE-1:0] mem_rsp_rdata,
    input  logic                  mem_rsp_err
);

    localparam int CW = $clog2(OUTS_DEPTH + 1);
    localparam int AW = (OUTS_DEPTH > 1) ? $clog2(OUTS_DEPTH) : 1;
    localparam logic [AW-1:0] LAST = AW'(OUTS_DEPTH - 1);

    logic [CW-1:0]         inflight;
    logic [CW-1:0]         kill_cnt;
    logic [CW-1:0]         fifo_cnt;
    logic [AW-1:0]         rd_ptr;
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         wr_idx;
    logic [INSTR_SIZE-1:0] fifo_instr [OUTS_DEPTH];
    logic                  fifo_err   [OUTS_DEPTH];

    logic                  aligned;
    logic                  credit;
    logic                  cmd_hs;
    logic                  mis_hs;
    logic                  rsp_take;
    logic                  rsp_push;
    logic                  push;
    logic                  pop;
    logic                  push_err;
    logic [INSTR_SIZE-1:0] push_instr;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == LAST) ? '0 : p + AW'(1);
    endfunction

    assign aligned       = (ifu_req_pc[1:0] == 2'b00);
    assign credit        = ({1'b0, inflight} + {1'b0, fifo_cnt}) < (CW+1)'(OUTS_DEPTH);
    assign mem_cmd_addr  = {ifu_req_pc[PC_SIZE-1:2], 2'b00};
    assign mem_rsp_ready = 1'b1;

    // Misaligned requests wait for an empty pipe so their error stays in order.
    always_comb begin
        ifu_req_ready = 1'b0;
        mem_cmd_valid = 1'b0;
        if (!rst) begin
            if (aligned) begin
                mem_cmd_valid = ifu_req_valid & credit;
                ifu_req_ready = mem_cmd_ready & credit;
            end else begin
                ifu_req_ready = credit & (inflight == '0);
            end
        end
    end

    assign cmd_hs     = mem_cmd_valid & mem_cmd_ready;
    assign mis_hs     = ifu_req_valid & ifu_req_ready & ~aligned;
    // Responses with nothing outstanding (e.g. stragglers after reset) are ignored.
    assign rsp_take   = mem_rsp_valid & (inflight != '0);
    assign rsp_push   = rsp_take & ~flush_req & (kill_cnt == '0);
    assign push       = rsp_push | mis_hs;
    assign push_err   = mis_hs | mem_rsp_err;
    assign push_instr = push_err ? INSTR_NOP : mem_rsp_rdata;
    assign pop        = ifu_rsp_valid & ifu_rsp_ready & ~flush_req;
    assign wr_idx     = flush_req ? '0 : wr_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= '0;
            kill_cnt <= '0;
            fifo_cnt <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            inflight <= inflight + CW'(cmd_hs) - CW'(rsp_take);
            if (flush_req) begin
                kill_cnt <= inflight - CW'(rsp_take);
            end else if (rsp_take && (kill_cnt != '0)) begin
                kill_cnt <= kill_cnt - CW'(1);
            end
            if (flush_req) begin
                rd_ptr   <= '0;
                wr_ptr   <= push ? ptr_inc('0) : '0;
                fifo_cnt <= CW'(push);
            end else begin
                if (push) wr_ptr <= ptr_inc(wr_ptr);
                if (pop)  rd_ptr <= ptr_inc(rd_ptr);
                fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_instr[wr_idx] <= push_instr;
            fifo_err[wr_idx]   <= push_err;
        end
    end

    assign ifu_rsp_valid = (fifo_cnt != '0);
    assign ifu_rsp_instr = ifu_rsp_valid ? fifo_instr[rd_ptr] : '0;
    assign ifu_rsp_err   = ifu_rsp_valid ? fifo_err[rd_ptr] : 1'b0;

endmodule

// File: tb/tb_ifu_ift2mem.sv
// tb/tb_ifu_ift2mem.sv - scoreboard bench for ifu_ift2mem
// Requests and a 1-cycle memory model are driven per cycle; expected words queue at accept.
module tb_ifu_ift2mem;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic [31:0] ifu_req_pc;
    logic        ifu_rsp_valid;
    logic        ifu_rsp_ready;
    logic [31:0] ifu_rsp_instr;
    logic        ifu_rsp_err;
    logic        flush_req;
    logic        mem_cmd_valid;
    logic        mem_cmd_ready;
    logic [31:0] mem_cmd_addr;
    logic        mem_rsp_valid;
    logic        mem_rsp_ready;
    logic [31:0] mem_rsp_rdata;
    logic        mem_rsp_err;

    ifu_ift2mem dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_pc(ifu_req_pc),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready),
        .ifu_rsp_instr(ifu_rsp_instr), .ifu_rsp_err(ifu_rsp_err),
        .flush_req(flush_req),
        .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready), .mem_cmd_addr(mem_cmd_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready),
        .mem_rsp_rdata(mem_rsp_rdata), .mem_rsp_err(mem_rsp_err)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    logic [31:0] req_q[$];
    logic [32:0] exp_q[$];
    logic [31:0] pend[$];
    int          acc_cyc[$];
    int          pop_cyc[$];
    bit          mem_auto;
    logic [31:0] err_addr;
    int          model_inflight;
    int          max_inflight;

    function automatic logic [31:0] rdata_of(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic cycle();
        bit          req_hs, cmd_hs, pop_hs;
        logic [31:0] pc, a;
        logic [32:0] e;
        ifu_req_valid = (req_q.size() > 0);
        ifu_req_pc    = (req_q.size() > 0) ? req_q[0] : 32'h0;
        #1;
        req_hs = ifu_req_valid && ifu_req_ready;
        cmd_hs = mem_cmd_valid && mem_cmd_ready;
        pop_hs = ifu_rsp_valid && ifu_rsp_ready && !flush_req;
        if (ifu_req_valid && (ifu_req_pc[1:0] != 2'b00)) begin
            checks++;
            if (mem_cmd_valid !== 1'b0) begin
                failures++;
                $display("FAIL misaligned_cmd pc=%h mem_cmd_valid=%b required 0", ifu_req_pc, mem_cmd_valid);
            end
        end
        if (cmd_hs) begin
            checks++;
            if (mem_cmd_addr !== {ifu_req_pc[31:2], 2'b00}) begin
                failures++;
                $display("FAIL cmd_addr got=%h required=%h", mem_cmd_addr, {ifu_req_pc[31:2], 2'b00});
            end
            pend.push_back(mem_cmd_addr);
            model_inflight++;
        end
        if (pop_hs) begin
            checks++;
            pop_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_rsp got err=%b instr=%h required none", ifu_rsp_err, ifu_rsp_instr);
            end else begin
                e = exp_q.pop_front();
                if ({ifu_rsp_err, ifu_rsp_instr} !== e) begin
                    failures++;
                    $display("FAIL rsp_data got err=%b instr=%h required err=%b instr=%h",
                             ifu_rsp_err, ifu_rsp_instr, e[32], e[31:0]);
                end
            end
        end
        if (flush_req) exp_q.delete();
        if (req_hs) begin
            pc = req_q.pop_front();
            acc_cyc.push_back(cyc);
            if (pc[1:0] != 2'b00 || pc == err_addr) exp_q.push_back({1'b1, NOP});
            else                                    exp_q.push_back({1'b0, rdata_of(pc)});
        end
        if (mem_rsp_valid && model_inflight > 0) model_inflight--;
        if (model_inflight > max_inflight) max_inflight = model_inflight;
        @(posedge clk);
        #1;
        cyc++;
        if (mem_auto && pend.size() > 0) begin
            a = pend.pop_front();
            mem_rsp_valid = 1'b1;
            mem_rsp_rdata = rdata_of(a);
            mem_rsp_err   = (a == err_addr);
        end else begin
            mem_rsp_valid = 1'b0;
            mem_rsp_rdata = 32'h0;
            mem_rsp_err   = 1'b0;
        end
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while ((req_q.size() > 0 || exp_q.size() > 0 || pend.size() > 0) && n < budget) begin
            cycle();
            n++;
        end
        checks++;
        if (req_q.size() > 0 || exp_q.size() > 0 || pend.size() > 0) begin
            failures++;
            $display("FAIL %s_drain_timeout reqs=%0d exp=%0d pend=%0d required all 0",
                     name, req_q.size(), exp_q.size(), pend.size());
        end
    endtask

    task automatic start_test();
        acc_cyc.delete();
        pop_cyc.delete();
        max_inflight = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ifu_req_valid = 1'b1;
        ifu_req_pc = 32'h80;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (ifu_req_ready !== 1'b0 || mem_cmd_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_req got ready=%b cmd_valid=%b required 0 0", ifu_req_ready, mem_cmd_valid);
        end
        checks++;
        if ({ifu_rsp_valid, ifu_rsp_err, ifu_rsp_instr} !== 34'h0) begin
            failures++;
            $display("FAIL reset_rsp got valid=%b err=%b instr=%h required 0 0 0",
                     ifu_rsp_valid, ifu_rsp_err, ifu_rsp_instr);
        end
        rst = 1'b0;
        ifu_req_valid = 1'b0;
        model_inflight = 0;
    endtask

    task automatic test_back_to_back();
        start_test();
        mem_auto = 1'b1;
        ifu_rsp_ready = 1'b1;
        req_q.push_back(32'h80);
        req_q.push_back(32'h84);
        req_q.push_back(32'h88);
        drain("b2b", 30);
        checks++;
        if (pop_cyc.size() != 3 || acc_cyc.size() != 3) begin
            failures++;
            $display("FAIL b2b_count got pops=%0d accepts=%0d required 3 3", pop_cyc.size(), acc_cyc.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (pop_cyc[i] != acc_cyc[i] + 2) begin
                    failures++;
                    $display("FAIL b2b_latency idx=%0d got=%0d required=%0d", i, pop_cyc[i], acc_cyc[i] + 2);
                end
            end
        end
        checks++;
        if (max_inflight > 2) begin
            failures++;
            $display("FAIL b2b_inflight got=%0d required<=2", max_inflight);
        end
    endtask

    task automatic test_back_pressure();
        start_test();
        mem_auto = 1'b1;
        ifu_rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) req_q.push_back(32'h10 + 32'(4 * i));
        repeat (6) cycle();
        checks++;
        if (acc_cyc.size() != 2) begin
            failures++;
            $display("FAIL bp_accepted got=%0d required=2", acc_cyc.size());
        end
        checks++;
        if (ifu_req_ready !== 1'b0 || ifu_rsp_valid !== 1'b1) begin
            failures++;
            $display("FAIL bp_stall got ready=%b rsp_valid=%b required 0 1", ifu_req_ready, ifu_rsp_valid);
        end
        ifu_rsp_ready = 1'b1;
        drain("bp", 40);
        checks++;
        if (pop_cyc.size() != 4) begin
            failures++;
            $display("FAIL bp_pops got=%0d required=4", pop_cyc.size());
        end
    endtask

    task automatic test_flush();
        start_test();
        mem_auto = 1'b0;
        ifu_rsp_ready = 1'b1;
        req_q.push_back(32'h100);
        req_q.push_back(32'h104);
        repeat (2) cycle();
        req_q.push_back(32'h200);
        flush_req = 1'b1;
        cycle();
        flush_req = 1'b0;
        checks++;
        if (acc_cyc.size() != 2) begin
            failures++;
            $display("FAIL flush_no_credit got accepts=%0d required=2", acc_cyc.size());
        end
        mem_auto = 1'b1;
        drain("flush", 30);
        checks++;
        if (pop_cyc.size() != 1) begin
            failures++;
            $display("FAIL flush_pops got=%0d required=1", pop_cyc.size());
        end
    endtask

    task automatic test_flush_accept();
        start_test();
        mem_auto = 1'b1;
        ifu_rsp_ready = 1'b1;
        req_q.push_back(32'h140);
        cycle();
        req_q.push_back(32'h240);
        flush_req = 1'b1;
        cycle();
        flush_req = 1'b0;
        checks++;
        if (acc_cyc.size() != 2) begin
            failures++;
            $display("FAIL flush_accept got accepts=%0d required=2", acc_cyc.size());
        end
        drain("flush_accept", 30);
        checks++;
        if (pop_cyc.size() != 1) begin
            failures++;
            $display("FAIL flush_accept_pops got=%0d required=1", pop_cyc.size());
        end
    endtask

    task automatic test_misaligned();
        start_test();
        mem_auto = 1'b0;
        ifu_rsp_ready = 1'b1;
        req_q.push_back(32'h300);
        req_q.push_back(32'h102);
        repeat (3) cycle();
        checks++;
        if (acc_cyc.size() != 1 || ifu_req_ready !== 1'b0) begin
            failures++;
            $display("FAIL mis_held got accepts=%0d ready=%b required 1 0", acc_cyc.size(), ifu_req_ready);
        end
        mem_auto = 1'b1;
        drain("mis", 30);
        checks++;
        if (acc_cyc.size() != 2 || pop_cyc.size() != 2) begin
            failures++;
            $display("FAIL mis_count got accepts=%0d pops=%0d required 2 2", acc_cyc.size(), pop_cyc.size());
        end else if (pop_cyc[1] != acc_cyc[1] + 1) begin
            failures++;
            $display("FAIL mis_latency got=%0d required=%0d", pop_cyc[1], acc_cyc[1] + 1);
        end
    endtask

    task automatic test_bus_error();
        start_test();
        mem_auto = 1'b1;
        ifu_rsp_ready = 1'b1;
        err_addr = 32'h40;
        req_q.push_back(32'h40);
        req_q.push_back(32'h44);
        drain("buserr", 30);
        checks++;
        if (pop_cyc.size() != 2) begin
            failures++;
            $display("FAIL buserr_pops got=%0d required=2", pop_cyc.size());
        end
        err_addr = 32'hFFFF_FFFF;
    endtask

    task automatic test_reset_mid();
        start_test();
        mem_auto = 1'b0;
        ifu_rsp_ready = 1'b0;
        req_q.push_back(32'h502);
        req_q.push_back(32'h504);
        repeat (3) cycle();
        req_q.push_back(32'h508);
        rst = 1'b1;
        cycle();
        checks++;
        if ({ifu_rsp_valid, ifu_rsp_err, ifu_rsp_instr} !== 34'h0) begin
            failures++;
            $display("FAIL rstmid_rsp got valid=%b err=%b instr=%h required 0 0 0",
                     ifu_rsp_valid, ifu_rsp_err, ifu_rsp_instr);
        end
        checks++;
        if (ifu_req_ready !== 1'b0 || mem_cmd_valid !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_req got ready=%b cmd_valid=%b required 0 0", ifu_req_ready, mem_cmd_valid);
        end
        req_q.delete();
        exp_q.delete();
        model_inflight = 0;
        rst = 1'b0;
        ifu_rsp_ready = 1'b1;
        mem_auto = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            checks++;
            if (ifu_rsp_valid !== 1'b0) begin
                failures++;
                $display("FAIL rstmid_stray cycle=%0d rsp_valid=%b required 0", i, ifu_rsp_valid);
            end
        end
        req_q.push_back(32'h508);
        drain("rstmid", 30);
        checks++;
        if (pop_cyc.size() != 1) begin
            failures++;
            $display("FAIL rstmid_pops got=%0d required=1", pop_cyc.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        ifu_req_valid = 1'b0;
        ifu_req_pc = 32'h0;
        ifu_rsp_ready = 1'b1;
        flush_req = 1'b0;
        mem_cmd_ready = 1'b1;
        mem_rsp_valid = 1'b0;
        mem_rsp_rdata = 32'h0;
        mem_rsp_err = 1'b0;
        mem_auto = 1'b1;
        err_addr = 32'hFFFF_FFFF;
        model_inflight = 0;
        max_inflight = 0;
        test_reset();
        test_back_to_back();
        test_back_pressure();
        test_flush();
        test_flush_accept();
        test_misaligned();
        test_bus_error();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
